noc_local_eject_switch: RTL

//  Local-port ejection crossbar. Sits directly downstream of the local port controller. Per VC it takes
//  the head of the controller's grant queue: a 5-bit one-hot input-port select.
//  It steers the granted packet's flits from that router input port to the single local NI link.
//  It pulses free_o[vc] on the tail flit, which pops the controller's grant queue.
//  VCs interleave flit-by-flit on the output through a round-robin VC arbiter and a registered skid buffer.

---
 rtl/noc_local_eject_switch_pkg.sv | 34 +++
 rtl/noc_local_eject_switch_if.sv | 34 +++
 rtl/noc_local_eject_switch_skid.sv | 52 +++++
 rtl/noc_local_eject_switch.sv | 121 ++++++++++++
 4 files changed

// File: rtl/noc_local_eject_switch_pkg.sv
// Shared types and constants for the local-port ejection crossbar.
// Holds the per-VC FSM state encoding, the router port indices and one-hot helpers.
package noc_local_eject_switch_pkg;

  localparam int NOC_VC_CHANNEL = 2;
  localparam int NOC_FLIT_WIDTH = 64;
  localparam int NUM_PORTS      = 5;
  localparam int PORT_IDX_W     = 3;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [1:0] {
    EJ_IDLE,
    EJ_ACTIVE,
    EJ_WAIT
  } eject_state_e;

  // Lowest set bit wins, so a malformed select still steers to a single port.
  function automatic logic [PORT_IDX_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    onehot_idx = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (oh[p]) onehot_idx = PORT_IDX_W'(p);
    end
  endfunction

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] oh);
    return (oh != '0) && ((oh & (oh - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/noc_local_eject_switch_if.sv
// Flit-level handshake bundle between the router input ports, the eject switch and the local NI.
// master = traffic source/sink side, slave = the eject switch.
interface noc_local_eject_switch_if
  import noc_local_eject_switch_pkg::*;
#(
  parameter int CHANNELS   = NOC_VC_CHANNEL,
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);

  logic [NUM_PORTS-1:0]                 in_valid;
  logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0][VC_W-1:0]       in_vc;
  logic [NUM_PORTS-1:0]                 in_tail;
  logic [NUM_PORTS-1:0]                 in_ready;

  logic                  out_valid;
  logic [FLIT_WIDTH-1:0] out_data;
  logic [VC_W-1:0]       out_vc;
  logic                  out_tail;
  logic                  out_ready;
  logic [CHANNELS-1:0]   out_vc_ready;

  modport master (
    output in_valid, in_data, in_vc, in_tail, out_ready, out_vc_ready,
    input  in_ready, out_valid, out_data, out_vc, out_tail
  );

  modport slave (
    input  in_valid, in_data, in_vc, in_tail, out_ready, out_vc_ready,
    output in_ready, out_valid, out_data, out_vc, out_tail
  );

endinterface

// File: rtl/noc_local_eject_switch_skid.sv
// Two-entry registered output stage: head_p1 drives the outputs directly, spare_p1 absorbs
// one flit of backpressure so the upstream ready never depends combinationally on out_ready.
module noc_local_eject_switch_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       count_p1;
  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] spare_p1;
  logic             push;
  logic             pop;

  assign in_ready  = (count_p1 != 2'd2);
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && (count_p1 != 2'd0);
  assign out_valid = (count_p1 != 2'd0);
  assign out_data  = head_p1;

  // Stage p1: skid storage
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1 <= '0;
      head_p1  <= '0;
      spare_p1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_p1 == 2'd0) head_p1 <= in_data;
          else                  spare_p1 <= in_data;
          count_p1 <= count_p1 + 2'd1;
        end
        2'b01: begin
          head_p1  <= spare_p1;
          count_p1 <= count_p1 - 2'd1;
        end
        // push blocks when full, so simultaneous push/pop only happens with one entry held
        2'b11:   head_p1 <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noc_local_eject_switch.sv
// Local-port ejection crossbar: per-VC grant FSMs steer flits from the granted router port,
// a round-robin VC arbiter interleaves them flit-by-flit into the registered skid stage.
module noc_local_eject_switch
  import noc_local_eject_switch_pkg::*;
#(
  parameter int CHANNELS   = NOC_VC_CHANNEL,
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                               noc_clk,
  input  logic                               noc_rst,
  input  logic [CHANNELS-1:0][NUM_PORTS-1:0] grant_i,
  output logic [CHANNELS-1:0]                free_o,
  output logic                               err_o,
  noc_local_eject_switch_if.slave            link
);

  localparam int SKID_W = FLIT_WIDTH + VC_W + 1;

  logic [CHANNELS-1:0]                 elig;
  logic [CHANNELS-1:0]                 err_vc;
  logic [CHANNELS-1:0]                 tail_done;
  logic [CHANNELS-1:0][PORT_IDX_W-1:0] port_of;
  logic [VC_W-1:0]                     rr_ptr;
  logic [VC_W-1:0]                     win;
  logic [PORT_IDX_W-1:0]               win_port;
  logic                                xfer;
  logic                                skid_ready;
  logic [NUM_PORTS-1:0]                ready;
  logic [SKID_W-1:0]                   skid_in;
  logic [SKID_W-1:0]                   skid_out;

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    eject_state_e         state;
    logic [NUM_PORTS-1:0] sel;

    assign port_of[v] = onehot_idx(sel);
    // Reset gating keeps a mid-packet reset from consuming a flit or popping the grant queue.
    assign elig[v] = !noc_rst && (state == EJ_ACTIVE)
                     && link.in_valid[port_of[v]]
                     && (link.in_vc[port_of[v]] == VC_W'(v))
                     && link.out_vc_ready[v] && skid_ready;
    assign tail_done[v] = xfer && (win == VC_W'(v)) && link.in_tail[port_of[v]];
    assign err_vc[v] = ((state == EJ_IDLE) && (grant_i[v] != '0) && !is_onehot(grant_i[v]))
                     || ((state == EJ_ACTIVE) && (grant_i[v] != sel));

    always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
        state <= EJ_IDLE;
        sel   <= '0;
      end else begin
        case (state)
          EJ_IDLE: begin
            if (grant_i[v] != '0) begin
              sel   <= grant_i[v];
              state <= EJ_ACTIVE;
            end
          end
          EJ_ACTIVE: if (tail_done[v]) state <= EJ_WAIT;
          // grant queue head is still the popped entry this cycle
          default:   state <= EJ_IDLE;
        endcase
      end
    end
  end

  // Round-robin pick: the eligible VC closest at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    xfer = 1'b0;
    win  = rr_ptr;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (elig[idx]) begin
        xfer = 1'b1;
        win  = VC_W'(idx);
      end
    end
  end

  assign win_port = port_of[win];
  assign skid_in  = {link.in_data[win_port], link.in_vc[win_port], link.in_tail[win_port]};

  always_comb begin
    ready  = '0;
    free_o = '0;
    if (xfer) begin
      ready[win_port] = 1'b1;
      free_o          = tail_done;
    end
  end

  assign link.in_ready = ready;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      rr_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= (int'(win) == CHANNELS - 1) ? '0 : win + 1'b1;
      if (|err_vc) err_o <= 1'b1;
    end
  end

  // Stage p0 -> p1: registered output stage toward the NI
  noc_local_eject_switch_skid #(.WIDTH(SKID_W)) u_skid (
    .clk       (noc_clk),
    .rst       (noc_rst),
    .in_valid  (xfer),
    .in_data   (skid_in),
    .in_ready  (skid_ready),
    .out_valid (link.out_valid),
    .out_data  (skid_out),
    .out_ready (link.out_ready)
  );

  assign {link.out_data, link.out_vc, link.out_tail} = skid_out;

endmodule
